flag_xfer_arbiter: RTL

Arbitrates N requesters onto one toggle-flag clock-domain-crossing channel (one-clock flag in, one-clock flag out in the destination domain), entirely in the source clock domain. Per transfer it:
- selects a winner round-robin;
- latches the winner's data word and holds it stable for the destination domain;
- emits exactly one `flag_out` pulse;
- blocks further issues until the crossing is safe.

It sits between the MIDI event sources (note on/off, control change) and the synth-domain flag synchronizer plus data capture register.

---
 rtl/flag_xfer_pkg.sv | 19 +
 rtl/flag_xfer_arbiter_rr.sv | 42 ++++
 rtl/flag_xfer_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/flag_xfer_pkg.sv
// Shared types and constants for the flag-crossing arbiter.
package flag_xfer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int DEF_N_REQ          = 4;
  localparam int DEF_DATA_W         = 16;
  localparam int DEF_GAP_CYCLES     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Bits needed to hold any count in 0..max_val.
  function automatic int cnt_width(input int max_val);
    cnt_width = $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/flag_xfer_arbiter_rr.sv
// Round-robin selector: combinational winner, pointer moves past the winner on advance.
module rr_arbiter
  import flag_xfer_pkg::*;
#(
  parameter int N = DEF_N_REQ
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  int            idx;

  // Scan from the lowest priority upward so the highest-priority hit is written last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % N;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/flag_xfer_arbiter.sv
// Arbitrates requesters onto a single toggle-flag crossing; one flag_out pulse per transfer.
// Build option FLAG_XFER_ACK_EN: wait for a synchronized ack edge (with timeout) instead of a fixed gap.
module flag_xfer_arbiter
  import flag_xfer_pkg::*;
#(
  parameter int N_REQ          = DEF_N_REQ,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         grant,
  output logic                     flag_out,
  output logic [DATA_W-1:0]        xfer_data,
  output logic [$clog2(N_REQ)-1:0] xfer_src,
  input  logic                     ack_toggle,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int IW      = $clog2(N_REQ);
  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0]   win_idx;
  logic            win_valid;
  logic            advance;

  assign advance = (state == IDLE) && win_valid;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .advance    (advance),
    .grant_idx  (win_idx),
    .grant_valid(win_valid)
  );

`ifdef FLAG_XFER_ACK_EN
  // Two synchronizer stages plus one history flop; the edge is seen one cycle after stage two.
  logic [2:0] ack_sync;
  logic       ack_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[1:0], ack_toggle};
    end
  end

  assign ack_edge = ack_sync[2] ^ ack_sync[1];
`else
  logic unused_ack;
  assign unused_ack  = ack_toggle;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      grant     <= '0;
      flag_out  <= 1'b0;
      xfer_data <= '0;
      xfer_src  <= '0;
      busy      <= 1'b0;
`ifdef FLAG_XFER_ACK_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      grant    <= '0;
      flag_out <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            grant     <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            flag_out  <= 1'b1;
            xfer_data <= req_data[win_idx*DATA_W +: DATA_W];
            xfer_src  <= win_idx;
            busy      <= 1'b1;
            state     <= WAIT;
`ifdef FLAG_XFER_ACK_EN
            cnt       <= CNT_W'(TIMEOUT_CYCLES - 1);
`else
            cnt       <= CNT_W'(GAP_CYCLES - 2);
`endif
          end
        end
        WAIT: begin
`ifdef FLAG_XFER_ACK_EN
          if (ack_edge) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
`else
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
